popcount_rr_scheduler: RTL and testbench
========================================

// Module: popcount_rr_scheduler
// PURPOSE
//   Time-shares one combinational 127-bit ones_counter between NREQ requesters.
//   Each requester submits a job of one or more 127-bit chunks. The block grants jobs
//   round-robin, steers the owner's chunks into the counter and accumulates the 7-bit
//   counts. It returns one total per job over a valid/ready result port.
// PARAMETERS
//   NREQ   4   number of requesters, 2..8
//   ID_W   2   width of requester index, = clog2(NREQ)
//   ACC_W  11  width of job accumulator/result; saturates at 2^ACC_W-1
// PORTS
//   clk        in   1        rising-edge clock
//   rst        in   1        synchronous, active-high reset
//   req_valid  in   NREQ     bit i: requester i presents a chunk
//   req_data   in   NREQ*127 chunk of requester i at [127*i+126:127*i]
//   req_last   in   NREQ     bit i: presented chunk is the last of the job
//   req_ready  out  NREQ     one-hot or zero; chunk accepted when valid&ready
//   pc_in      out  127      to ones_counter input i
//   pc_cnt     in   7        from ones_counter output S (same-cycle, combinational)
//   res_valid  out  1        job result available
//   res_ready  in   1        consumer accepts result
//   res_id     out  ID_W     requester index of result
//   res_count  out  ACC_W    total ones in job
//   res_sat    out  1        accumulator saturated during job
//   busy       out  1        state != IDLE
// BEHAVIOUR
//   Reset (sync, rst=1 at edge): state=IDLE, rr_ptr=0, owner=0, acc=0, res_valid=0,
//     res_id=0, res_count=0, res_sat=0. req_ready=0 and pc_in=0 while in IDLE/RESP.
//     rst has priority over every other event.
//   States: IDLE -> RUN -> RESP -> IDLE.
//   IDLE: if any req_valid, owner <= first set bit searching rr_ptr, rr_ptr+1, ... (mod NREQ).
//     Go to RUN and set acc=0, sat=0. req_ready stays 0 in this cycle: 1-cycle arbitration bubble.
//   RUN: req_ready[owner]=req_valid[owner], all other bits 0. pc_in = owner's req_data.
//     On accept: acc <= sat_add(acc, pc_cnt); sat flag set if the sum exceeds 2^ACC_W-1.
//     Accept with req_last[owner]=1: res_count <= sat_add(acc,pc_cnt), res_id <= owner,
//       res_sat <= updated flag, res_valid <= 1, go to RESP.
//     Owner valid low: stall. acc unchanged, pc_in=0, ownership held (no pre-emption).
//     Other requesters' valids are ignored until the job ends. No limit on chunk count.
//   RESP: res_valid=1; res_id/res_count/res_sat stable until res_valid&res_ready.
//     On handshake: res_valid <= 0, rr_ptr <= (owner+1) mod NREQ, go to IDLE.
//   Latency: a 1-chunk job asserted at cycle t in IDLE is accepted at t+1.
//     res_valid is high from t+2. With res_ready=1, the next grant decision is at t+3.
//   pc_cnt is trusted; the block adds no register between pc_in and pc_cnt.
//   Reset mid-job discards the partial count. The requester must resend from its first chunk.
// TESTING
//   1 rst, then req_valid=0001, req_data[0]=all ones, last=1, res_ready=1
//     -> req_ready=0001 at t+1; res_valid at t+2, res_id=0, res_count=127, res_sat=0.
//   2 req 1 job: chunks 0x...01, all ones, 0 (last)
//     -> three accepts, res_id=1, res_count=128.
//   3 all four requesters hold 1-chunk jobs from reset
//     -> results in order id 0,1,2,3, then 0 again; never two req_ready bits high.
//   4 res_ready=0 for 5 cycles in RESP -> res_* stable, req_ready=0000, busy=1;
//     completes on the 6th cycle.
//   5 owner drops req_valid for 3 cycles mid-job while req 2 is valid
//     -> acc unchanged, req 2 not granted, final count correct.
//   6 17 all-ones chunks -> res_count=2047, res_sat=1.
//     Assert rst mid-job -> next cycle IDLE, all outputs 0.

Source files
------------

// File: rtl/popcount_rr_scheduler_if.sv
// Requester and result ports of the round-robin popcount scheduler.
// Handshake: a transfer happens on a rising clk edge where valid && ready; valid never waits on ready.
interface popcount_rr_scheduler_if #(
  parameter int NREQ  = 4,
  parameter int ID_W  = 2,
  parameter int ACC_W = 11
);
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*127-1:0] req_data;
  logic [NREQ-1:0]     req_last;
  logic [NREQ-1:0]     req_ready;
  logic                res_valid;
  logic                res_ready;
  logic [ID_W-1:0]     res_id;
  logic [ACC_W-1:0]    res_count;
  logic                res_sat;

  modport master (
    output req_valid, req_data, req_last, res_ready,
    input  req_ready, res_valid, res_id, res_count, res_sat
  );

  modport slave (
    input  req_valid, req_data, req_last, res_ready,
    output req_ready, res_valid, res_id, res_count, res_sat
  );
endinterface

// File: rtl/popcount_rr_scheduler.sv
// Shares one external 127-bit ones counter between NREQ requesters, granting whole jobs
// round-robin and returning one saturating total per job.
module popcount_rr_scheduler #(
  parameter int NREQ  = 4,
  parameter int ID_W  = 2,
  parameter int ACC_W = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  popcount_rr_scheduler_if.slave bus,
  output logic [126:0]          pc_in,
  input  logic [6:0]            pc_cnt,
  output logic                  busy,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  owner_q, owner_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             sat_q, sat_d;
  logic             res_valid_q, res_valid_d;
  logic [ID_W-1:0]  res_id_q, res_id_d;
  logic [ACC_W-1:0] res_count_q, res_count_d;
  logic             res_sat_q, res_sat_d;

  logic             grant_found;
  logic [ID_W-1:0]  grant_idx;
  int               scan_idx;
  logic             owner_valid;
  logic             owner_last;
  logic [126:0]     owner_data;
  logic [ACC_W:0]   sum_w;
  logic [ACC_W-1:0] sat_sum;
  logic [ID_W-1:0]  owner_next;
  logic [NREQ-1:0]  req_ready_c;

  // Round-robin search starting at rr_ptr, wrapping modulo NREQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = int'(rr_ptr_q) + k;
      if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
      if (!grant_found && bus.req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(scan_idx);
      end
    end
  end

  always_comb begin
    owner_valid = bus.req_valid[owner_q];
    owner_last  = bus.req_last[owner_q];
    owner_data  = bus.req_data[int'(owner_q)*127 +: 127];
    sum_w       = {1'b0, acc_q} + {{(ACC_W-6){1'b0}}, pc_cnt};
    sat_sum     = sum_w[ACC_W] ? {ACC_W{1'b1}} : sum_w[ACC_W-1:0];
    owner_next  = (owner_q == ID_W'(NREQ-1)) ? '0 : owner_q + 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    acc_d       = acc_q;
    sat_d       = sat_q;
    res_valid_d = res_valid_q;
    res_id_d    = res_id_q;
    res_count_d = res_count_q;
    res_sat_d   = res_sat_q;
    req_ready_c = '0;
    pc_in       = '0;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          owner_d = grant_idx;
          acc_d   = '0;
          sat_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Only the owner is ever offered ready; a stalled owner keeps the counter input at zero.
        req_ready_c[owner_q] = owner_valid;
        if (owner_valid) begin
          pc_in = owner_data;
          acc_d = sat_sum;
          sat_d = sat_q | sum_w[ACC_W];
          if (owner_last) begin
            res_count_d = sat_sum;
            res_id_d    = owner_q;
            res_sat_d   = sat_q | sum_w[ACC_W];
            res_valid_d = 1'b1;
            state_d     = RESP;
          end
        end
      end
      RESP: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          rr_ptr_d    = owner_next;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_count_q <= '0;
      res_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      acc_q       <= acc_d;
      sat_q       <= sat_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_count_q <= res_count_d;
      res_sat_q   <= res_sat_d;
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.res_valid = res_valid_q;
  assign bus.res_id    = res_id_q;
  assign bus.res_count = res_count_q;
  assign bus.res_sat   = res_sat_q;
  assign busy          = (state_q != IDLE);
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_popcount_rr_scheduler.sv
// Testbench for popcount_rr_scheduler: per-requester chunk queues drive the ports,
// expected job totals go into exp_q and are compared at each result handshake.
module tb_popcount_rr_scheduler;
  localparam int NREQ  = 4;
  localparam int ID_W  = 2;
  localparam int ACC_W = 11;
  localparam int MAXC  = 64;
  localparam int MAXV  = (1 << ACC_W) - 1;
  localparam int EW    = ID_W + ACC_W + 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  popcount_rr_scheduler_if #(.NREQ(NREQ), .ID_W(ID_W), .ACC_W(ACC_W)) bus ();
  logic [126:0] pc_in;
  logic [6:0]   pc_cnt;
  logic         busy;
  logic [1:0]   state_dbg;

  // Ones-counter model feeding back combinationally.
  assign pc_cnt = 7'($countones(pc_in));

  popcount_rr_scheduler #(.NREQ(NREQ), .ID_W(ID_W), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .pc_in     (pc_in),
    .pc_cnt    (pc_cnt),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  int n_checks;
  int n_errors;
  int n_acc;
  logic [EW-1:0]   exp_q[$];
  logic [126:0]    jdata [NREQ][MAXC];
  logic            jlast [NREQ][MAXC];
  int              jlen  [NREQ];
  int              jpos  [NREQ];
  int              job_sum [NREQ];
  logic [NREQ-1:0] hold;
  logic [NREQ-1:0] acc_bits;
  bit              push_en;

  task automatic check(input string tag, input logic [126:0] got, input logic [126:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (jpos[i] < jlen[i]) begin
        bus.req_valid[i]             = !hold[i];
        bus.req_data[i*127 +: 127]   = jdata[i][jpos[i]];
        bus.req_last[i]              = jlast[i][jpos[i]];
      end else begin
        bus.req_valid[i]             = 1'b0;
        bus.req_data[i*127 +: 127]   = '0;
        bus.req_last[i]              = 1'b0;
      end
    end
  endtask

  task automatic add_chunk(input int i, input logic [126:0] d, input bit last);
    logic [ID_W-1:0]  eid;
    logic [ACC_W-1:0] ecnt;
    jdata[i][jlen[i]] = d;
    jlast[i][jlen[i]] = last;
    jlen[i]++;
    job_sum[i] += $countones(d);
    if (last) begin
      eid  = ID_W'(i);
      ecnt = (job_sum[i] > MAXV) ? ACC_W'(MAXV) : ACC_W'(job_sum[i]);
      if (push_en) exp_q.push_back({eid, ecnt, job_sum[i] > MAXV});
      job_sum[i] = 0;
    end
  endtask

  task automatic clear_jobs();
    for (int i = 0; i < NREQ; i++) begin
      jlen[i] = 0; jpos[i] = 0; job_sum[i] = 0;
    end
    hold = '0;
    acc_bits = '0;
  endtask

  // scoreboard: sampled on the falling edge
  task automatic sample();
    logic [EW-1:0] e;
    @(negedge clk);
    acc_bits = bus.req_valid & bus.req_ready;
    check("ready_onehot0", 127'($countones(bus.req_ready) <= 1), 127'(1));
    for (int i = 0; i < NREQ; i++) begin
      if (acc_bits[i]) begin
        n_acc++;
        check("pc_in", pc_in, jdata[i][jpos[i]]);
      end
    end
    if (bus.res_valid && bus.res_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 127'(1), 127'(0));
      end else begin
        e = exp_q.pop_front();
        check("res_id",    127'(bus.res_id),    127'(e[EW-1 -: ID_W]));
        check("res_count", 127'(bus.res_count), 127'(e[ACC_W:1]));
        check("res_sat",   127'(bus.res_sat),   127'(e[0]));
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) if (acc_bits[i]) jpos[i]++;
    drive();
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  task automatic run_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
    check("drain_timeout", 127'(exp_q.size()), 127'(0));
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_jobs();
    exp_q.delete();
    push_en = 1'b1;
    bus.res_ready = 1'b1;
    drive();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_state"},     127'(state_dbg),     127'(0));
    check({tag, "_busy"},      127'(busy),          127'(0));
    check({tag, "_res_valid"}, 127'(bus.res_valid), 127'(0));
    check({tag, "_res_id"},    127'(bus.res_id),    127'(0));
    check({tag, "_res_count"}, 127'(bus.res_count), 127'(0));
    check({tag, "_res_sat"},   127'(bus.res_sat),   127'(0));
    check({tag, "_req_ready"}, 127'(bus.req_ready), 127'(0));
    check({tag, "_pc_in"},     pc_in,               127'(0));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] r;
    int n;
    n_checks = 0;
    n_errors = 0;
    n_acc    = 0;
    rst      = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.res_ready = 1'b1;
    do_reset();

    sample();
    check_idle_zero("reset");
    advance();

    // 1: single all-ones chunk, latency t / t+1 / t+2
    do_reset();
    add_chunk(0, '1, 1'b1);
    drive();
    sample();
    check("t1_bubble_ready", 127'(bus.req_ready), 127'(0));
    advance();
    sample();
    check("t1_ready",     127'(bus.req_ready), 127'(4'b0001));
    check("t1_res_early", 127'(bus.res_valid), 127'(0));
    advance();
    sample();
    check("t1_res_valid", 127'(bus.res_valid), 127'(1));
    check("t1_popped",    127'(exp_q.size()),  127'(0));
    advance();
    run_drain(10);

    // 2: three-chunk job on requester 1
    do_reset();
    n_acc = 0;
    add_chunk(1, 127'h1, 1'b0);
    add_chunk(1, '1, 1'b0);
    add_chunk(1, 127'h0, 1'b1);
    drive();
    run_drain(30);
    check("t2_accepts", 127'(n_acc), 127'(3));

    // 3: all requesters busy from reset, round-robin order 0,1,2,3,0
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      add_chunk(i, r[126:0], 1'b1);
    end
    r = {$urandom, $urandom, $urandom, $urandom};
    add_chunk(0, r[126:0], 1'b1);
    drive();
    run_drain(60);

    // 4: result back-pressure for 5 cycles
    do_reset();
    bus.res_ready = 1'b0;
    add_chunk(0, 127'hff, 1'b1);
    add_chunk(1, 127'h3, 1'b1);
    drive();
    n = 0;
    sample();
    while (!bus.res_valid && n < 20) begin
      advance();
      sample();
      n++;
    end
    check("t4_wait_res", 127'(bus.res_valid), 127'(1));
    for (int k = 0; k < 5; k++) begin
      check("t4_res_id",    127'(bus.res_id),    127'(0));
      check("t4_res_count", 127'(bus.res_count), 127'(8));
      check("t4_res_valid", 127'(bus.res_valid), 127'(1));
      check("t4_req_ready", 127'(bus.req_ready), 127'(0));
      check("t4_busy",      127'(busy),          127'(1));
      advance();
      if (k < 4) sample();
    end
    bus.res_ready = 1'b1;
    sample();
    check("t4_completed", 127'(exp_q.size()), 127'(1));
    advance();
    run_drain(20);

    // 5: owner stalls mid-job while requester 2 waits
    do_reset();
    add_chunk(0, 127'h5,  1'b0);
    add_chunk(0, 127'hf0, 1'b0);
    add_chunk(0, 127'h7,  1'b0);
    add_chunk(0, 127'h1,  1'b1);
    add_chunk(2, 127'h3f, 1'b1);
    drive();
    n = 0;
    while (jpos[0] < 2 && n < 20) begin
      cycle();
      n++;
    end
    check("t5_reach_mid", 127'(jpos[0]), 127'(2));
    hold[0] = 1'b1;
    drive();
    for (int k = 0; k < 3; k++) begin
      sample();
      check("t5_no_grant", 127'(bus.req_ready), 127'(0));
      check("t5_pc_zero",  pc_in,               127'(0));
      check("t5_busy",     127'(busy),          127'(1));
      advance();
    end
    hold[0] = 1'b0;
    drive();
    run_drain(40);

    // 6: saturation, then reset mid-job and resend
    do_reset();
    for (int k = 0; k < 17; k++) add_chunk(3, '1, k == 16);
    drive();
    run_drain(60);

    push_en = 1'b0;
    for (int k = 0; k < 5; k++) add_chunk(0, 127'hff, k == 4);
    drive();
    n = 0;
    while (jpos[0] < 2 && n < 20) begin
      cycle();
      n++;
    end
    rst = 1'b1;
    clear_jobs();
    drive();
    @(posedge clk);
    #1;
    rst = 1'b0;
    sample();
    check_idle_zero("t6_rst");
    advance();
    push_en = 1'b1;
    for (int k = 0; k < 5; k++) add_chunk(0, 127'hff, k == 4);
    drive();
    run_drain(40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
